// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - opcode codes understood by the downstream ALU
//   - bit positions of the fields inside the 16-bit instruction word
//   - FSM state encoding of the issue sequencer
package alu_pkg;

  localparam logic [2:0] OP_SUMA        = 3'd0;
  localparam logic [2:0] OP_COMPLEMENTO = 3'd1;
  localparam logic [2:0] OP_SHIFT_R     = 3'd2;
  localparam logic [2:0] OP_SHIFT_L     = 3'd3;
  localparam logic [2:0] OP_COMPC       = 3'd4;
  localparam logic [2:0] OP_COMPN       = 3'd5;
  localparam logic [2:0] OP_LOAD        = 3'd6;
  localparam logic [2:0] OP_SAVE        = 3'd7;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 13;
  localparam int unsigned REG_MSB = 12;
  localparam int unsigned REG_LSB = 10;
  localparam int unsigned POS_BIT = 9;
  localparam int unsigned RSV_BIT = 8;
  localparam int unsigned DAT_MSB = 7;
  localparam int unsigned DAT_LSB = 0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StErr
  } state_e;

endpackage

// File: rtl/alu_instr_fifo.sv
// alu_instr_fifo: synchronous FIFO holding encoded instruction words.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_push, i_data write i_data at the tail (ignored when full)
//   i_pop          drop the head entry (ignored when empty)
//   o_data         head entry, valid combinationally while !o_empty
//   o_full/o_empty occupancy flags
module alu_instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issue stage in front of the ALU. Buffers instruction words,
// decodes the head into the ALU operand outputs, pulses alu_start once per
// instruction and waits for alu_done before issuing the next one.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_instr    upstream handshake and instruction word
//   alu_opcode/registro/posicion/datos  decoded fields, held until next pop
//   alu_start                     one-cycle launch pulse
//   alu_done                      ALU completion, only looked at in WAIT
//   busy                          work queued or in flight
//   timeout_err                   sticky, ALU failed to complete in time
//   issued_count                  completed instructions, mod 256
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_instr,
  output logic [2:0]   alu_opcode,
  output logic [2:0]   alu_registro,
  output logic         alu_posicion,
  output logic [7:0]   alu_datos,
  output logic         alu_start,
  input  logic         alu_done,
  output logic         busy,
  output logic         timeout_err,
  output logic [7:0]   issued_count
);

  state_e       r_state;
  state_e       w_state_d;
  logic [3:0]   r_wait_cnt;
  logic [3:0]   w_wait_d;
  logic         w_done_ok;
  logic         w_to_err;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [15:0]  w_head;
  logic         w_unused_rsvd;

  logic [2:0]   r_opcode;
  logic [2:0]   r_registro;
  logic         r_posicion;
  logic [7:0]   r_datos;
  logic         r_start;
  logic         r_err;
  logic [7:0]   r_issued;

  assign in_ready = !w_full && (r_state != StErr);
  assign busy     = !w_empty || (r_state != StIdle);
  assign w_pop    = (r_state == StIdle) && !w_empty;

  // Reserved instruction bit has no consumer.
  assign w_unused_rsvd = w_head[RSV_BIT];

  alu_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid && in_ready),
    .i_pop   (w_pop),
    .i_data  (in_instr),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_d = r_state;
    w_wait_d  = r_wait_cnt;
    w_done_ok = 1'b0;
    w_to_err  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) w_state_d = StIssue;
      end
      StIssue: begin
        w_state_d = StWait;
        w_wait_d  = '0;
      end
      StWait: begin
        // w_wait_d is the number of the WAIT cycle now in progress.
        w_wait_d = r_wait_cnt + 4'd1;
        if (alu_done) begin
          w_state_d = StIdle;
          w_done_ok = 1'b1;
        end else if (w_wait_d == 4'(TIMEOUT)) begin
          w_state_d = StErr;
          w_to_err  = 1'b1;
        end
      end
      StErr: begin
        w_state_d = StErr;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
      r_opcode   <= '0;
      r_registro <= '0;
      r_posicion <= 1'b0;
      r_datos    <= '0;
      r_start    <= 1'b0;
      r_err      <= 1'b0;
      r_issued   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_d;
      r_start    <= w_pop;
      if (w_pop) begin
        r_opcode   <= w_head[OPC_MSB:OPC_LSB];
        r_registro <= w_head[REG_MSB:REG_LSB];
        r_posicion <= w_head[POS_BIT];
        r_datos    <= w_head[DAT_MSB:DAT_LSB];
      end
      if (w_to_err)  r_err    <= 1'b1;
      if (w_done_ok) r_issued <= r_issued + 8'd1;
    end
  end

  assign alu_opcode   = r_opcode;
  assign alu_registro = r_registro;
  assign alu_posicion = r_posicion;
  assign alu_datos    = r_datos;
  assign alu_start    = r_start;
  assign timeout_err  = r_err;
  assign issued_count = r_issued;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Testbench for alu_issue_seq: a queue-based reference model advances on each
// clock edge; a monitor compares the DUT against it on the falling edge and
// scoreboards every alu_start against the word the model expects to issue.
module tb_alu_issue_seq;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int M_IDLE  = 0;
  localparam int M_ISSUE = 1;
  localparam int M_WAIT  = 2;
  localparam int M_ERR   = 3;
  localparam int NEVER   = 100;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  alu_opcode;
  logic [2:0]  alu_registro;
  logic        alu_posicion;
  logic [7:0]  alu_datos;
  logic        alu_start;
  logic        alu_done;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  issued_count;

  alu_issue_seq #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .alu_opcode   (alu_opcode),
    .alu_registro (alu_registro),
    .alu_posicion (alu_posicion),
    .alu_datos    (alu_datos),
    .alu_start    (alu_start),
    .alu_done     (alu_done),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .issued_count (issued_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle", name, act, exp);
    end
  endtask

  // Reference model state.
  logic [15:0] m_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_last;
  int          m_mode;
  int          m_wait;
  int          m_lat;
  int          m_cnt;
  bit          m_err;
  bit          m_start;
  bit          m_acc;
  int          cyc = 0;
  int          start_cyc[$];
  int          lat_cfg = 1;
  bit          noise_en = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_mode  = M_IDLE;
      m_wait  = 0;
      m_lat   = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
      m_start = 1'b0;
      m_last  = '0;
    end else begin
      m_acc   = in_valid && (m_q.size() < DEPTH) && (m_mode != M_ERR);
      m_start = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (m_q.size() > 0) begin
            m_last = m_q.pop_front();
            exp_q.push_back(m_last);
            m_mode  = M_ISSUE;
            m_start = 1'b1;
            m_lat   = (lat_cfg == 0) ? int'($urandom_range(1, 6)) : lat_cfg;
          end
        end
        M_ISSUE: begin
          m_mode = M_WAIT;
          m_wait = 0;
        end
        M_WAIT: begin
          m_wait++;
          if (alu_done) begin
            m_cnt  = (m_cnt + 1) % 256;
            m_mode = M_IDLE;
          end else if (m_wait == TIMEOUT) begin
            m_mode = M_ERR;
            m_err  = 1'b1;
          end
        end
        default: ;
      endcase
      if (m_acc) m_q.push_back(in_instr);
    end
  end

  // ALU responder: completes on the chosen WAIT cycle; optional spurious done elsewhere.
  always @(negedge clk) begin
    alu_done = ((m_mode == M_WAIT) && (m_wait + 1 == m_lat)) ||
               (noise_en && (m_mode == M_ISSUE || m_mode == M_IDLE));
  end

  // Monitor / scoreboard.
  logic [15:0] sb_w;
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, int'(m_q.size() < DEPTH && m_mode != M_ERR));
      check("busy", busy, int'(m_q.size() != 0 || m_mode != M_IDLE));
      check("timeout_err", timeout_err, m_err);
      check("issued_count", issued_count, m_cnt);
      check("alu_start", alu_start, m_start);
      check("alu_hold", {alu_opcode, alu_registro, alu_posicion, alu_datos},
            {m_last[15:9], m_last[7:0]});
      if (alu_start) begin
        start_cyc.push_back(cyc);
        check("sb_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          sb_w = exp_q.pop_front();
          check("sb_opcode", alu_opcode, sb_w[15:13]);
          check("sb_registro", alu_registro, sb_w[12:10]);
          check("sb_posicion", alu_posicion, sb_w[9]);
          check("sb_datos", alu_datos, sb_w[7:0]);
        end
      end
    end
  end

  int acc_cyc;

  // Offer a word and hold it until accepted (bounded).
  task automatic push(input logic [15:0] w);
    bit acc;
    int n = 0;
    in_valid = 1'b1;
    in_instr = w;
    do begin
      acc = in_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 100);
    in_valid = 1'b0;
    acc_cyc  = cyc;
    check("push_accept", acc, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] words [8];
    int acc;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    alu_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset values.
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", alu_start, 0);
    check("rst_err", timeout_err, 0);
    check("rst_count", issued_count, 0);
    check("rst_opcode", alu_opcode, 0);

    // Single issue, done in the first WAIT cycle.
    lat_cfg = 1;
    start_cyc.delete();
    push(16'h0C05);
    repeat (6) @(negedge clk);
    check("single_nstart", start_cyc.size(), 1);
    if (start_cyc.size() > 0) check("single_latency", start_cyc[0] - acc_cyc, 1);
    check("single_opcode", alu_opcode, 0);
    check("single_registro", alu_registro, 3);
    check("single_datos", alu_datos, 8'h05);
    check("single_count", issued_count, 1);

    // Fill with a stalled ALU: the first word leaves for the ALU immediately,
    // so DEPTH+1 words get in before in_ready drops and the next is held.
    do_reset();
    lat_cfg = NEVER;
    for (int i = 0; i < 8; i++) words[i] = 16'h2000 + 16'(i);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = words[acc];
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("fill_accepted", acc, DEPTH + 1);
    check("fill_ready", in_ready, 0);

    // Order with two WAIT cycles per instruction.
    do_reset();
    lat_cfg = 2;
    start_cyc.delete();
    push(16'hE011);
    push(16'hC622);
    push(16'hA233);
    push(16'h8E44);
    repeat (25) @(negedge clk);
    check("order_nstart", start_cyc.size(), 4);
    for (int i = 1; i < start_cyc.size(); i++)
      check("order_spacing", start_cyc[i] - start_cyc[i-1], 4);
    check("order_count", issued_count, 4);

    // Timeout.
    do_reset();
    lat_cfg = NEVER;
    start_cyc.delete();
    push(16'h4C7F);
    repeat (20) @(negedge clk);
    check("to_err", timeout_err, 1);
    check("to_ready", in_ready, 0);
    check("to_nstart", start_cyc.size(), 1);
    do_reset();
    check("to_cleared", timeout_err, 0);

    // Done on exactly the TIMEOUT-th WAIT cycle, with spurious done in ISSUE.
    lat_cfg  = TIMEOUT;
    noise_en = 1'b1;
    push(16'h6A5A);
    repeat (25) @(negedge clk);
    noise_en = 1'b0;
    check("bnd_err", timeout_err, 0);
    check("bnd_count", issued_count, 1);

    // Reset mid-WAIT with three words queued.
    do_reset();
    lat_cfg = NEVER;
    push(16'h1111);
    push(16'h3222);
    push(16'h5333);
    push(16'h7444);
    repeat (2) @(negedge clk);
    check("mid_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_count", issued_count, 0);
    check("mid_ready", in_ready, 1);
    start_cyc.delete();
    repeat (10) @(negedge clk);
    check("mid_nstart", start_cyc.size(), 0);

    // Randomized traffic with random ALU latency.
    do_reset();
    lat_cfg = 0;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(16'($urandom()));
    end
    repeat (60) @(negedge clk);
    check("rand_drained", busy, 0);
    check("rand_count", issued_count, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
